alu_responder: RTL and testbench
================================

# alu_responder

Handshaked request/response front end for the 16-bit ALU. It accepts operand/opcode requests on a valid/ready channel, evaluates the ALU function (ADD/SUB/AND/OR/SLT) and queues each result with its zero flag in a small response FIFO. Results are returned in order on a second valid/ready channel. It is the responder side of the ALU operation interface and replaces bench-style direct driving of the ALU when a sequencer or CPU datapath issues operations with back-pressure.

## Interface
- Parameters:
- DEPTH, 2, response FIFO entries; power of two, 2..16.
- Ports:
- clk  input  1  single clock; all state updates on rising edge.
- rst  input  1  asynchronous, active-high reset.
- req_valid  input  1  request present.
- req_ready  output  1  responder can accept; `req_ready = (count < DEPTH)`; registered-state only, no combinational path from rsp_ready.
- req_a  input  16  operand A.
- req_b  input  16  operand B.
- req_op  input  3  0 ADD, 1 SUB, 2 AND, 3 OR, 4 SLT, 5..7 illegal.
- rsp_valid  output  1  head FIFO entry valid (`count != 0`).
- rsp_ready  input  1  consumer takes head entry.
- rsp_o  output  16  result at FIFO head.
- rsp_zero  output  1  `rsp_o == 0` for head entry.
- rsp_err  output  1  head entry came from an illegal opcode.
- op_count  output  16  completed-response counter; present only with ALU_STATS_EN.

## Operation
- Push when `req_valid && req_ready`: compute the result combinationally from req_a/req_b/req_op and write {o, zero, err} at the write pointer.
- Pop when `rsp_valid && rsp_ready`: advance the read pointer.
- Pointers are log2(DEPTH) bits and wrap modulo DEPTH. count is 0..DEPTH.
- Arithmetic:
  - ADD = (A+B) mod 2^16; carry discarded.
  - SUB = (A−B) mod 2^16.
  - AND and OR are bitwise.
  - SLT = 16'd1 if $signed(A) < $signed(B), else 16'd0.
- Illegal op (5..7): o = 0, zero = 1, err = 1. The entry is still queued and consumes a slot.
- zero is computed from the stored o; it never reflects a stale entry.
- Ordering: strictly FIFO; responses leave in acceptance order.
- Simultaneous push and pop: count is unchanged and both pointers advance.
- When full, no push occurs in that cycle even if a pop happens in the same cycle, because req_ready is low.
- Empty: rsp_o/rsp_zero/rsp_err show the storage at the read pointer. They are don't-care while rsp_valid = 0.
- Reset (including mid-operation) clears pointers and count and discards all queued results. Requests in flight are lost; the requester must reissue them.

## Timing
- Reset values:
  - req_ready = 1
  - rsp_valid = 0
  - rsp_o = 0
  - rsp_zero = 1
  - rsp_err = 0
  - op_count = 0
  - FIFO storage cleared to {0, 1, 0}.
- Latency: a request accepted at edge N has its response visible with rsp_valid = 1 in the cycle after edge N (one cycle), provided earlier entries have drained.
- Throughput: one request and one response per cycle sustained when rsp_ready is held high, for DEPTH ≥ 2.
- rsp_o/rsp_zero/rsp_err stay stable while rsp_valid = 1 and rsp_ready = 0.
- Requesters must hold req_* stable while req_valid = 1 and req_ready = 0.

## Configuration
- ALU_STATS_EN defined:
  - op_count port exists.
  - op_count increments by 1 on every pop and wraps 16'hFFFF → 0.
  - Cleared by rst.
- ALU_STATS_EN undefined: op_count port and counter are absent; all other behaviour is identical.

## Test plan
- Reset → req_ready = 1, rsp_valid = 0, rsp_zero = 1, rsp_err = 0 (op_count = 0 if enabled). Then A = 11, B = 3, ops 0..3 issued back to back with rsp_ready = 1 → responses 14, 8, 3, 11 in order, one per cycle, zero = 0.
- SLT cases:
  - A = 3, B = 11 → 1.
  - A = 11, B = 3 → 0.
  - A = 16'hFFFF (−1), B = 1 → 1.
  - ADD 16'hFFFF + 1 → 0 with zero = 1.
  - SUB 7 − 7 → 0 with zero = 1.
- Back-pressure, DEPTH = 2, rsp_ready = 0: push two requests → req_ready = 0 and a third req_valid is not accepted. Raise rsp_ready for one cycle → one pop; req_ready returns to 1 the next cycle; ordering is preserved.
- Illegal op 6 with A = 5, B = 5 → rsp_o = 0, rsp_zero = 1, rsp_err = 1; the next legal ADD 1 + 1 → 2 with err = 0.
- Assert rst with 2 entries queued → rsp_valid falls immediately (asynchronously); after release, a new ADD 2 + 2 returns 4 as the first response.
- ALU_STATS_EN: 5 pops → op_count = 5. Force 65536 pops (or preload in a long run) → op_count wraps to 0.

Source files
------------

// File: rtl/alu_responder.sv
`default_nettype none
// ============================================================================
// Module   : alu_responder
// Brief    : Valid/ready front end for the 16-bit ALU (ADD/SUB/AND/OR/SLT).
//            Results are queued with zero/err flags in a DEPTH-entry FIFO.
//            Optional macro ALU_STATS_EN adds the op_count response counter.
// Revision : 1.0 - initial release
// ============================================================================
module alu_responder #(
    parameter int DEPTH = 2
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        req_valid,
    output logic        req_ready,
    input  logic [15:0] req_a,
    input  logic [15:0] req_b,
    input  logic [2:0]  req_op,
    output logic        rsp_valid,
    input  logic        rsp_ready,
    output logic [15:0] rsp_o,
    output logic        rsp_zero,
    output logic        rsp_err
`ifdef ALU_STATS_EN
    ,
    output logic [15:0] op_count
`endif
);

    localparam int c_AW = (DEPTH > 1) ? $clog2(DEPTH) : 1;
    localparam int c_CW = c_AW + 1;

    logic [15:0]     r_mem_o [DEPTH];
    logic [DEPTH-1:0] r_mem_zero;
    logic [DEPTH-1:0] r_mem_err;
    logic [c_AW-1:0] r_wr_ptr;
    logic [c_AW-1:0] r_rd_ptr;
    logic [c_CW-1:0] r_count;

    logic        w_push;
    logic        w_pop;
    logic [15:0] w_res;
    logic        w_err;

    // Ready depends only on registered occupancy, never on rsp_ready.
    assign req_ready = (r_count < c_CW'(DEPTH));
    assign rsp_valid = (r_count != '0);
    assign w_push    = req_valid && req_ready;
    assign w_pop     = rsp_valid && rsp_ready;

    assign rsp_o    = r_mem_o[r_rd_ptr];
    assign rsp_zero = r_mem_zero[r_rd_ptr];
    assign rsp_err  = r_mem_err[r_rd_ptr];

    always_comb begin
        w_res = 16'd0;
        w_err = 1'b0;
        case (req_op)
            3'd0:    w_res = req_a + req_b;
            3'd1:    w_res = req_a - req_b;
            3'd2:    w_res = req_a & req_b;
            3'd3:    w_res = req_a | req_b;
            3'd4:    w_res = {15'd0, ($signed(req_a) < $signed(req_b))};
            default: w_err = 1'b1;
        endcase
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            for (int i = 0; i < DEPTH; i++) begin
                r_mem_o[i] <= 16'd0;
            end
            r_mem_zero <= '1;
            r_mem_err  <= '0;
            r_wr_ptr   <= '0;
            r_rd_ptr   <= '0;
            r_count    <= '0;
        end else begin
            if (w_push) begin
                r_mem_o[r_wr_ptr]    <= w_res;
                r_mem_zero[r_wr_ptr] <= (w_res == 16'd0);
                r_mem_err[r_wr_ptr]  <= w_err;
                r_wr_ptr             <= r_wr_ptr + 1'b1;
            end
            if (w_pop) begin
                r_rd_ptr <= r_rd_ptr + 1'b1;
            end
            case ({w_push, w_pop})
                2'b10:   r_count <= r_count + 1'b1;
                2'b01:   r_count <= r_count - 1'b1;
                default: r_count <= r_count;
            endcase
        end
    end

`ifdef ALU_STATS_EN
    logic [15:0] r_op_count;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_op_count <= 16'd0;
        end else if (w_pop) begin
            r_op_count <= r_op_count + 16'd1;
        end
    end

    assign op_count = r_op_count;
`endif

endmodule
`default_nettype wire

// File: tb/tb_alu_responder.sv
`default_nettype none
// ============================================================================
// Module   : tb_alu_responder
// Brief    : Randomized + directed bench for alu_responder against a queue model.
// Revision : 1.0 - initial release
// ============================================================================
module tb_alu_responder;

    localparam int DEPTH = 2;

    logic        clk;
    logic        rst;
    logic        req_valid;
    logic        req_ready;
    logic [15:0] req_a;
    logic [15:0] req_b;
    logic [2:0]  req_op;
    logic        rsp_valid;
    logic        rsp_ready;
    logic [15:0] rsp_o;
    logic        rsp_zero;
    logic        rsp_err;
`ifdef ALU_STATS_EN
    logic [15:0] op_count;
`endif

    alu_responder #(.DEPTH(DEPTH)) dut (
        .clk       (clk),
        .rst       (rst),
        .req_valid (req_valid),
        .req_ready (req_ready),
        .req_a     (req_a),
        .req_b     (req_b),
        .req_op    (req_op),
        .rsp_valid (rsp_valid),
        .rsp_ready (rsp_ready),
        .rsp_o     (rsp_o),
        .rsp_zero  (rsp_zero),
        .rsp_err   (rsp_err)
`ifdef ALU_STATS_EN
        ,
        .op_count  (op_count)
`endif
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    int n_cmp = 0;
    int n_bad = 0;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_bad++;
            $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
        end
    endtask

    // Reference model: an entry is {o, zero, err}.
    function automatic logic [17:0] model_alu(input logic [15:0] a, input logic [15:0] b,
                                              input logic [2:0] op);
        int sa;
        int sb;
        logic [15:0] o;
        sa = int'($signed(a));
        sb = int'($signed(b));
        case (op)
            3'd0: o = 16'((int'(a) + int'(b)) % 65536);
            3'd1: o = 16'((int'(a) - int'(b) + 65536) % 65536);
            3'd2: o = a & b;
            3'd3: o = a | b;
            3'd4: o = (sa < sb) ? 16'd1 : 16'd0;
            default: return {16'd0, 1'b1, 1'b1};
        endcase
        return {o, (o == 16'd0), 1'b0};
    endfunction

    logic [17:0] mq[$];
    bit          m_last_push;
    logic [15:0] m_ops;
    bit          m_push;
    bit          m_pop;

    always @(posedge clk or posedge rst) begin
        if (rst) begin
            mq.delete();
            m_last_push = 1'b0;
            m_ops       = 16'd0;
        end else begin
            m_push = req_valid && (mq.size() < DEPTH);
            m_pop  = (mq.size() != 0) && rsp_ready;
            if (m_pop) begin
                mq.delete(0);
                m_ops = m_ops + 16'd1;
            end
            if (m_push) mq.push_back(model_alu(req_a, req_b, req_op));
            m_last_push = m_push;
        end
    end

    always @(negedge clk) begin
        if (!rst) begin
            chk("req_ready", req_ready, (mq.size() < DEPTH));
            chk("rsp_valid", rsp_valid, (mq.size() != 0));
            if (mq.size() != 0) begin
                chk("rsp_head", {rsp_o, rsp_zero, rsp_err}, mq[0]);
            end
`ifdef ALU_STATS_EN
            chk("op_count", op_count, m_ops);
`endif
        end
    end

    task automatic step();
        @(posedge clk);
        #2;
    endtask

    task automatic one(input logic [15:0] a, input logic [15:0] b, input logic [2:0] op,
                       input logic [15:0] eo, input logic ez, input logic ee);
        req_a = a; req_b = b; req_op = op; req_valid = 1'b1; rsp_ready = 1'b0;
        step();
        req_valid = 1'b0;
        chk($sformatf("one_valid op%0d", op), rsp_valid, 1);
        chk($sformatf("one_o a=%0h b=%0h op%0d", a, b, op), rsp_o, eo);
        chk($sformatf("one_zero op%0d", op), rsp_zero, ez);
        chk($sformatf("one_err op%0d", op), rsp_err, ee);
        rsp_ready = 1'b1;
        step();
        rsp_ready = 1'b0;
    endtask

    initial begin
        #10_000_000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        logic [15:0] exp_b2b [4];
        bit stall;
        exp_b2b[0] = 16'd14; exp_b2b[1] = 16'd8; exp_b2b[2] = 16'd3; exp_b2b[3] = 16'd11;

        rst = 1'b1; req_valid = 1'b0; req_a = '0; req_b = '0; req_op = '0; rsp_ready = 1'b0;
        repeat (3) step();
        chk("rst_req_ready", req_ready, 1);
        chk("rst_rsp_valid", rsp_valid, 0);
        chk("rst_rsp_o", rsp_o, 0);
        chk("rst_rsp_zero", rsp_zero, 1);
        chk("rst_rsp_err", rsp_err, 0);
`ifdef ALU_STATS_EN
        chk("rst_op_count", op_count, 0);
`endif
        rst = 1'b0;
        step();

        // Back-to-back ops 0..3 on A=11, B=3 with consumer always ready.
        req_a = 16'd11; req_b = 16'd3; rsp_ready = 1'b1; req_valid = 1'b1;
        for (int k = 0; k < 4; k++) begin
            req_op = 3'(k);
            step();
            chk($sformatf("b2b_valid%0d", k), rsp_valid, 1);
            chk($sformatf("b2b_o%0d", k), rsp_o, exp_b2b[k]);
            chk($sformatf("b2b_zero%0d", k), rsp_zero, 0);
        end
        req_valid = 1'b0;
        step();
        rsp_ready = 1'b0;

        one(16'd3, 16'd11, 3'd4, 16'd1, 1'b0, 1'b0);
        one(16'd11, 16'd3, 3'd4, 16'd0, 1'b1, 1'b0);
        one(16'hFFFF, 16'd1, 3'd4, 16'd1, 1'b0, 1'b0);
        one(16'hFFFF, 16'd1, 3'd0, 16'd0, 1'b1, 1'b0);
        one(16'd7, 16'd7, 3'd1, 16'd0, 1'b1, 1'b0);

        // Back-pressure: fill, refuse third, single pop, then accept it.
        rsp_ready = 1'b0; req_op = 3'd0;
        req_a = 16'd1; req_b = 16'd1; req_valid = 1'b1; step();
        req_a = 16'd2; req_b = 16'd2; step();
        chk("bp_full_ready", req_ready, 0);
        chk("bp_head0", rsp_o, 2);
        req_a = 16'd3; req_b = 16'd3; step();
        chk("bp_refused_ready", req_ready, 0);
        chk("bp_head1", rsp_o, 2);
        rsp_ready = 1'b1; step(); rsp_ready = 1'b0;
        chk("bp_ready_back", req_ready, 1);
        chk("bp_head2", rsp_o, 4);
        step();
        req_valid = 1'b0;
        chk("bp_full_again", req_ready, 0);
        rsp_ready = 1'b1; step();
        chk("bp_head3", rsp_o, 6);
        step();
        chk("bp_empty", rsp_valid, 0);
        rsp_ready = 1'b0;

        one(16'd5, 16'd5, 3'd6, 16'd0, 1'b1, 1'b1);
        one(16'd1, 16'd1, 3'd0, 16'd2, 1'b0, 1'b0);

        // Asynchronous reset with two entries queued.
        req_op = 3'd2; req_a = 16'h00F0; req_b = 16'h0FF0; req_valid = 1'b1;
        step(); step();
        req_valid = 1'b0;
        chk("mid_queued", rsp_valid, 1);
        rst = 1'b1;
        #1;
        chk("mid_rst_valid", rsp_valid, 0);
        chk("mid_rst_ready", req_ready, 1);
        chk("mid_rst_zero", rsp_zero, 1);
        chk("mid_rst_err", rsp_err, 0);
        step();
        rst = 1'b0;
        step();
        one(16'd2, 16'd2, 3'd0, 16'd4, 1'b0, 1'b0);

        // Randomized traffic; held requests stay stable while stalled.
        for (int i = 0; i < 400; i++) begin
            stall = req_valid && !m_last_push;
            if (!stall) begin
                req_valid = ($urandom_range(0, 3) != 0);
                req_a = 16'($urandom);
                req_b = ($urandom_range(0, 7) == 0) ? req_a : 16'($urandom);
                req_op = ($urandom_range(0, 9) > 7) ? 3'($urandom_range(5, 7))
                                                    : 3'($urandom_range(0, 4));
            end
            rsp_ready = ($urandom_range(0, 2) != 0);
            step();
        end
        req_valid = 1'b0; rsp_ready = 1'b1;
        repeat (4) step();
        rsp_ready = 1'b0;

`ifdef ALU_STATS_EN
        rst = 1'b1; step(); rst = 1'b0; step();
        for (int i = 0; i < 5; i++) one(16'(i), 16'd1, 3'd0, 16'(i + 1), 1'b0, 1'b0);
        chk("stats_five", op_count, 5);
        req_op = 3'd3; req_a = 16'h1234; req_b = 16'h0001; req_valid = 1'b1; rsp_ready = 1'b1;
        repeat (65531) step();
        req_valid = 1'b0;
        step();
        rsp_ready = 1'b0;
        chk("stats_wrap", op_count, 0);
`endif

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
`default_nettype wire
